tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one tristate bus among N_REQ drivers.
- Each driver is a tristate 2-to-1 mux/flip-flop stage with an active-high enable.
- Guarantees at most one driver enable is high at any time, enforces a dead (turnaround) gap between owners, and bounds ownership time.
- Sits beside the tristate driver stages; its drv_en vector feeds their enable inputs directly.

Parameters:
- N_REQ, 4, number of requesters/drivers (2..8).
- MAX_HOLD, 8, maximum owned cycles before preemption when another request is pending (1..255).
- TURN_CYC, 1, dead cycles with all enables low between owners (1..7).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request per driver; held high while the driver wants the bus.
- lock  input  1  when high, suppresses preemption of the current owner; ignored when no owner.
- grant  output  N_REQ  one-hot-or-zero, registered; identifies current owner.
- drv_en  output  N_REQ  tristate enables, registered; equals grant in OWN state, zero otherwise.
- owner_id  output  clog2(N_REQ)  binary index of owner; 0 when no owner.
- bus_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, any time, including mid-ownership):
  - grant = 0, drv_en = 0, owner_id = 0, bus_busy = 0.
  - State = IDLE, rr pointer = 0, hold_cnt = 0, turn_cnt = 0.
  - Outputs clear immediately, not at the next edge.
- States: IDLE, OWN, TURN.
- Arbitration: search indices ptr, ptr+1, ... ptr+N_REQ-1 (mod N_REQ); the first set req bit wins. On each grant to k, ptr <= (k+1) mod N_REQ.
- IDLE:
  - If req != 0 at an edge, arbitrate. Next cycle: state OWN, grant = drv_en = one-hot(k), owner_id = k, hold_cnt = 1.
  - Latency from req sampled high to drv_en high is 1 cycle.
- OWN:
  - Each edge, hold_cnt increments, saturating at MAX_HOLD.
  - Exit to TURN (grant = drv_en = 0 next cycle, turn_cnt = 1) when either condition holds:
    - (a) req[owner] low at the edge; or
    - (b) hold_cnt == MAX_HOLD, lock low, and some other req bit high.
  - Otherwise stay. With no competitor, or with lock high, the owner keeps the bus indefinitely.
  - Release (a) always passes through TURN, even if no other requester is pending.
- TURN:
  - All enables low; bus_busy high.
  - While turn_cnt < TURN_CYC, turn_cnt increments.
  - At the edge where turn_cnt == TURN_CYC: arbitrate over current req.
    - Winner present: go to OWN (same effects as from IDLE).
    - No winner: go to IDLE.
  - The just-released owner is eligible again, at lowest round-robin priority.
- Invariants:
  - drv_en never has more than one bit set.
  - drv_en is never nonzero on the cycle immediately after a different nonzero value. At least TURN_CYC zero cycles lie between distinct owners.
  - grant == drv_en at all times.
- Simultaneous events:
  - Owner drop and competitor request at the same edge: resolved as release (a), then TURN.
  - Request rising during TURN is considered at TURN exit.
- owner_id holds its value only while in OWN; it is 0 in IDLE and TURN.
- lock rising at the same edge as the preemption condition suppresses preemption.

Test Plan:
- Reset/single request:
  - Stimulus: rst_n=0, then release; req=4'b0010 from cycle 2, dropped at cycle 6.
  - Required: drv_en=0010 and owner_id=1 at cycles 3..6; drv_en=0 at cycle 7 (TURN); IDLE at cycle 8 with bus_busy=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held constant, MAX_HOLD=8, TURN_CYC=1.
  - Required: owners 0,1,2,3,0 in order; each drives exactly 8 cycles; exactly 1 zero cycle between owners.
- Lock:
  - Stimulus: owner 2 with lock=1, req=4'b0101 for 20 cycles.
  - Required: owner 2 retains drv_en=0100 for all 20 cycles; preempted at the first edge after lock falls, since hold_cnt is saturated at 8.
- Mutual exclusion:
  - Stimulus: random req and lock for 10k cycles.
  - Required (assertions): drv_en is always onehot0, grant == drv_en, and there is a zero gap of at least TURN_CYC cycles between owner changes.
- Async reset mid-operation:
  - Stimulus: owner 3 active; rst_n falls between clock edges.
  - Required: drv_en, grant and bus_busy read 0 in the same timestep. After release with req=4'b1001, owner 0 is granted first (ptr=0).
- Owner-drop race:
  - Stimulus: owner 0 drops req at the same edge req[1] rises, TURN_CYC=3.
  - Required: exactly 3 zero cycles, then drv_en=0010.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus: one enable at a time,
// a dead gap between owners, and bounded ownership when others are waiting.
module tristate_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             lock,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] drv_en,
    output logic [ID_W-1:0]  owner_id,
    output logic             bus_busy
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [2:0] TURN_MAX = 3'(TURN_CYC);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [7:0]       hold_cnt;
    logic [2:0]       turn_cnt;

    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  cand;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  next_ptr;
    logic             start_own;
    logic             release_own;

    // First requester at or after the round-robin pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot = N_REQ'(1) << win_idx;
        next_ptr   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end

    always_comb begin
        start_own   = win_found &&
                      ((state == IDLE) || (state == TURN && turn_cnt == TURN_MAX));
        release_own = !req[owner_id] ||
                      (hold_cnt == HOLD_MAX && !lock && |(req & ~grant));
    end

    // drv_en is its own flop so the driver enables come straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            grant    <= '0;
            drv_en   <= '0;
            owner_id <= '0;
            bus_busy <= 1'b0;
        end else if (start_own) begin
            state    <= OWN;
            grant    <= win_onehot;
            drv_en   <= win_onehot;
            owner_id <= win_idx;
            ptr      <= next_ptr;
            hold_cnt <= 8'd1;
            turn_cnt <= '0;
            bus_busy <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus_busy <= 1'b0;
                end
                OWN: begin
                    if (release_own) begin
                        state    <= TURN;
                        grant    <= '0;
                        drv_en   <= '0;
                        owner_id <= '0;
                        hold_cnt <= '0;
                        turn_cnt <= 3'd1;
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt < TURN_MAX) begin
                        turn_cnt <= turn_cnt + 3'd1;
                    end else begin
                        state    <= IDLE;
                        turn_cnt <= '0;
                        bus_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two parameterisations share stimulus and are
// compared every cycle against an owner/gap model, plus directed literal checks.
module tb_tristate_bus_arbiter;

    localparam int N      = 4;
    localparam int HOLD_A = 8;
    localparam int TURN_A = 1;
    localparam int HOLD_B = 3;
    localparam int TURN_B = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic         lock  = 1'b0;

    logic [N-1:0] grant_a, drv_a, grant_b, drv_b;
    logic [1:0]   id_a, id_b;
    logic         busy_a, busy_b;

    tristate_bus_arbiter #(.N_REQ(N), .MAX_HOLD(HOLD_A), .TURN_CYC(TURN_A)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .grant    (grant_a),
        .drv_en   (drv_a),
        .owner_id (id_a),
        .bus_busy (busy_a)
    );

    tristate_bus_arbiter #(.N_REQ(N), .MAX_HOLD(HOLD_B), .TURN_CYC(TURN_B)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .grant    (grant_b),
        .drv_en   (drv_b),
        .owner_id (id_b),
        .bus_busy (busy_b)
    );

    always #5 clk = ~clk;

    // owner < 0 means nobody holds the bus; gap > 0 counts dead cycles so far.
    typedef struct packed {
        int owner;
        int ptr;
        int held;
        int gap;
    } model_t;

    model_t ma, mb;
    int checks = 0;
    int errors = 0;

    logic [N-1:0] prev_drv [2];
    int           zero_run [2];
    bit           seen     [2];

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.ptr   = 0;
        m.held  = 0;
        m.gap   = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [N-1:0] r,
                                          input logic l, input int max_hold,
                                          input int turn_cyc);
        model_t n;
        bit     pick;
        int     k;
        n    = m;
        pick = 1'b0;
        if (m.owner >= 0) begin
            if (!r[2'(m.owner)] ||
                (m.held == max_hold && !l && (r & ~(N'(1) << m.owner)) != '0)) begin
                n.owner = -1;
                n.held  = 0;
                n.gap   = 1;
            end else if (m.held < max_hold) begin
                n.held = m.held + 1;
            end
        end else if (m.gap > 0 && m.gap < turn_cyc) begin
            n.gap = m.gap + 1;
        end else begin
            pick = 1'b1;
        end
        if (pick) begin
            n.gap = 0;
            for (int i = 0; i < N; i++) begin
                k = (m.ptr + i) % N;
                if (n.owner < 0 && r[2'(k)]) begin
                    n.owner = k;
                    n.held  = 1;
                    n.ptr   = (k + 1) % N;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] exp_grant(input model_t m);
        return (m.owner >= 0) ? (N'(1) << m.owner) : '0;
    endfunction

    function automatic logic [1:0] exp_id(input model_t m);
        return (m.owner >= 0) ? 2'(m.owner) : 2'd0;
    endfunction

    function automatic logic exp_busy(input model_t m);
        return (m.owner >= 0) || (m.gap > 0);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_instance(input int i, input string tag, input logic [N-1:0] g,
                                  input logic [N-1:0] d, input logic [1:0] id,
                                  input logic b, input model_t m, input int turn_cyc);
        check_output({tag, "_grant"}, 32'(g), 32'(exp_grant(m)));
        check_output({tag, "_drv_en"}, 32'(d), 32'(exp_grant(m)));
        check_output({tag, "_owner_id"}, 32'(id), 32'(exp_id(m)));
        check_output({tag, "_bus_busy"}, 32'(b), 32'(exp_busy(m)));
        check_output({tag, "_onehot0"}, 32'($onehot0(d)), 32'd1);
        check_output({tag, "_grant_eq_drv"}, 32'(g), 32'(d));
        if (!rst_n) begin
            prev_drv[i] = '0;
            zero_run[i] = 0;
            seen[i]     = 1'b0;
        end else if (d != '0) begin
            if (prev_drv[i] != '0 && prev_drv[i] != d)
                check_output({tag, "_direct_handover"}, 32'(d), 32'(prev_drv[i]));
            if (prev_drv[i] == '0 && seen[i])
                check_output({tag, "_gap_short"}, 32'(zero_run[i] >= turn_cyc), 32'd1);
            seen[i]     = 1'b1;
            zero_run[i] = 0;
            prev_drv[i] = d;
        end else begin
            zero_run[i] = zero_run[i] + 1;
            prev_drv[i] = d;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= model_step(ma, req, lock, HOLD_A, TURN_A);
            mb <= model_step(mb, req, lock, HOLD_B, TURN_B);
        end
    end

    always @(negedge clk) begin
        check_instance(0, "a", grant_a, drv_a, id_a, busy_a, ma, TURN_A);
        check_instance(1, "b", grant_b, drv_b, id_b, busy_b, mb, TURN_B);
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r, input logic l);
        @(negedge clk);
        req  = r;
        lock = l;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        ma = model_reset();
        mb = model_reset();
        for (int i = 0; i < 2; i++) begin
            prev_drv[i] = '0;
            zero_run[i] = 0;
            seen[i]     = 1'b0;
        end

        repeat (2) @(negedge clk);
        check_output("reset_drv_en", 32'(drv_a), 32'd0);
        check_output("reset_bus_busy", 32'(busy_a), 32'd0);
        check_output("reset_owner_id", 32'(id_a), 32'd0);
        #1 rst_n = 1'b1;

        // Single request held for four owned cycles, then released.
        apply_stimulus(4'b0010, 1'b0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            check_output("single_drv_en", 32'(drv_a), 32'h2);
            check_output("single_owner_id", 32'(id_a), 32'd1);
        end
        check_output("model_pin_owner", 32'(exp_grant(ma)), 32'h2);
        req = '0;
        @(negedge clk);
        check_output("single_turn_drv_en", 32'(drv_a), 32'd0);
        check_output("single_turn_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        check_output("single_idle_busy", 32'(busy_a), 32'd0);
        check_output("model_pin_idle", 32'(exp_busy(ma)), 32'd0);
        repeat (4) @(negedge clk);

        // All four requesting: strict rotation, full hold, single dead cycle.
        do_reset();
        apply_stimulus(4'b1111, 1'b0);
        for (int o = 0; o < 5; o++) begin
            for (int h = 0; h < HOLD_A; h++) begin
                @(negedge clk);
                check_output("rr_owner_drv_en", 32'(drv_a), 32'(N'(1) << order[o]));
            end
            if (o < 4) begin
                @(negedge clk);
                check_output("rr_gap_drv_en", 32'(drv_a), 32'd0);
            end
        end
        req = '0;
        repeat (6) @(negedge clk);

        // Lock keeps owner 2 beyond saturation; preemption right after unlock.
        do_reset();
        apply_stimulus(4'b0100, 1'b1);
        apply_stimulus(4'b0101, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_output("lock_hold_drv_en", 32'(drv_a), 32'h4);
        end
        lock = 1'b0;
        @(negedge clk);
        check_output("lock_preempt_drv_en", 32'(drv_a), 32'd0);
        @(negedge clk);
        check_output("lock_next_owner", 32'(drv_a), 32'h1);
        req = '0;
        repeat (6) @(negedge clk);

        // Asynchronous reset while owner 3 drives.
        do_reset();
        apply_stimulus(4'b1000, 1'b0);
        @(negedge clk);
        check_output("areset_pre_drv_en", 32'(drv_a), 32'h8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("areset_a_drv_en", 32'(drv_a), 32'd0);
        check_output("areset_a_grant", 32'(grant_a), 32'd0);
        check_output("areset_a_busy", 32'(busy_a), 32'd0);
        check_output("areset_b_drv_en", 32'(drv_b), 32'd0);
        check_output("areset_b_busy", 32'(busy_b), 32'd0);
        req = 4'b1001;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("areset_first_a", 32'(drv_a), 32'h1);
        check_output("areset_first_b", 32'(drv_b), 32'h1);
        req = '0;
        repeat (6) @(negedge clk);

        // Owner 0 drops as requester 1 rises: three dead cycles on the b instance.
        do_reset();
        apply_stimulus(4'b0001, 1'b0);
        @(negedge clk);
        check_output("race_pre_b", 32'(drv_b), 32'h1);
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("race_gap_b", 32'(drv_b), 32'd0);
            if (c == 1)
                check_output("race_owner_a", 32'(drv_a), 32'h2);
        end
        @(negedge clk);
        check_output("race_owner_b", 32'(drv_b), 32'h2);
        req = '0;
        repeat (6) @(negedge clk);

        // Random requests, lock and occasional resets.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            #1;
            if (!rst_n)
                rst_n = 1'b1;
            else if ($urandom_range(0, 1999) == 0)
                rst_n = 1'b0;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0)
                    req[b] = ~req[b];
            if ($urandom_range(0, 15) == 0)
                lock = ~lock;
        end
        rst_n = 1'b1;

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
